nios2_jtag_debug_host: RTL and testbench

// Sysclk-domain initiator for the Nios II debug module's 2-bit-IR virtual-JTAG interface. Drives the target's vji_* state/clock signals.

---
 rtl/nios2_jtag_debug_host.sv | 167 ++++++++++++++++
 tb/tb_nios2_jtag_debug_host.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios2_jtag_debug_host.sv
// Sysclk-domain virtual-JTAG scan initiator for the Nios II debug module.
// One accepted command runs UIR->CDR->SDR->UDR->RTI and returns the captured DR word.
module nios2_jtag_debug_host #(
  parameter int DR_W       = 38,
  parameter int IR_W       = 2,
  parameter int TCK_DIV    = 2,
  parameter int RTI_CYCLES = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic [IR_W-1:0] cmd_ir_i,
  input  logic [DR_W-1:0] cmd_dr_i,
  output logic            rsp_valid_o,
  output logic [DR_W-1:0] rsp_dr_o,
  output logic            busy_o,
  output logic            vji_tck_o,
  output logic            vji_tdi_o,
  input  logic            vji_tdo_i,
  output logic [IR_W-1:0] vji_ir_in_o,
  output logic            vji_uir_o,
  output logic            vji_cdr_o,
  output logic            vji_sdr_o,
  output logic            vji_udr_o,
  output logic            vji_rti_o
);

  localparam int PW      = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
  localparam int CNT_MAX = (DR_W > RTI_CYCLES) ? DR_W : RTI_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [PW-1:0] PHASE_LOAD = PW'(TCK_DIV - 1);
  localparam logic [CW-1:0] SDR_LOAD   = CW'(DR_W - 1);
  localparam logic [CW-1:0] RTI_LOAD   = CW'(RTI_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, UIR, CDR, SDR, UDR, RTI, DONE} state_e;

  state_e          state_q;
  logic [PW-1:0]   phase_q;
  logic [CW-1:0]   bit_q;
  logic [DR_W-1:0] sr_q;
  logic [DR_W-1:0] cap_q;
  logic [DR_W-1:0] rsp_dr_q;
  logic [IR_W-1:0] ir_q;
  logic            ready_q, busy_q, rsp_valid_q;
  logic            tck_q, tdi_q, uir_q, cdr_q, sdr_q, udr_q, rti_q;

  // bit_q holds the remaining tck cycles of the current state minus one
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      bit_q       <= '0;
      sr_q        <= '0;
      cap_q       <= '0;
      rsp_dr_q    <= '0;
      ir_q        <= '0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      tck_q       <= 1'b0;
      tdi_q       <= 1'b0;
      uir_q       <= 1'b0;
      cdr_q       <= 1'b0;
      sdr_q       <= 1'b0;
      udr_q       <= 1'b0;
      rti_q       <= 1'b1;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid_i && ready_q) begin
            ir_q    <= cmd_ir_i;
            sr_q    <= cmd_dr_i;
            cap_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            uir_q   <= 1'b1;
            rti_q   <= 1'b0;
            tck_q   <= 1'b0;
            phase_q <= PHASE_LOAD;
            bit_q   <= '0;
            state_q <= UIR;
          end
        end
        DONE: begin
          rsp_valid_q <= 1'b1;
          rsp_dr_q    <= cap_q;
          ready_q     <= 1'b1;
          busy_q      <= 1'b0;
          rti_q       <= 1'b1;
          state_q     <= IDLE;
        end
        default: begin
          if (phase_q != '0) begin
            phase_q <= phase_q - 1'b1;
          end else begin
            phase_q <= PHASE_LOAD;
            if (!tck_q) begin
              // last clk of the low half: sample tdo before tck rises
              tck_q <= 1'b1;
              if (state_q == SDR) cap_q <= {vji_tdo_i, cap_q[DR_W-1:1]};
            end else begin
              tck_q <= 1'b0;
              if (bit_q != '0) begin
                bit_q <= bit_q - 1'b1;
                if (state_q == SDR) begin
                  tdi_q <= sr_q[0];
                  sr_q  <= sr_q >> 1;
                end
              end else begin
                case (state_q)
                  UIR: begin
                    uir_q   <= 1'b0;
                    cdr_q   <= 1'b1;
                    bit_q   <= '0;
                    state_q <= CDR;
                  end
                  CDR: begin
                    cdr_q   <= 1'b0;
                    sdr_q   <= 1'b1;
                    tdi_q   <= sr_q[0];
                    sr_q    <= sr_q >> 1;
                    bit_q   <= SDR_LOAD;
                    state_q <= SDR;
                  end
                  SDR: begin
                    sdr_q   <= 1'b0;
                    udr_q   <= 1'b1;
                    tdi_q   <= 1'b0;
                    bit_q   <= '0;
                    state_q <= UDR;
                  end
                  UDR: begin
                    udr_q   <= 1'b0;
                    rti_q   <= 1'b1;
                    bit_q   <= RTI_LOAD;
                    state_q <= RTI;
                  end
                  default: begin
                    rti_q   <= 1'b0;
                    bit_q   <= '0;
                    state_q <= DONE;
                  end
                endcase
              end
            end
          end
        end
      endcase
    end
  end

  assign cmd_ready_o = ready_q;
  assign busy_o      = busy_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_dr_o    = rsp_dr_q;
  assign vji_tck_o   = tck_q;
  assign vji_tdi_o   = tdi_q;
  assign vji_ir_in_o = ir_q;
  assign vji_uir_o   = uir_q;
  assign vji_cdr_o   = cdr_q;
  assign vji_sdr_o   = sdr_q;
  assign vji_udr_o   = udr_q;
  assign vji_rti_o   = rti_q;

endmodule

// File: tb/tb_nios2_jtag_debug_host.sv
// Bench for nios2_jtag_debug_host: a default instance plus a TCK_DIV=1 instance,
// each driven against a behavioural virtual-JTAG target shift register.
module tb_nios2_jtag_debug_host;

  localparam int DR_W       = 38;
  localparam int IR_W       = 2;
  localparam int TCK_DIV    = 2;
  localparam int RTI_CYCLES = 4;
  localparam int SCAN_TCKS  = DR_W + 3 + RTI_CYCLES;
  localparam int LAT        = 2 * TCK_DIV * SCAN_TCKS + 1;
  localparam int LAT_F      = 2 * 1 * SCAN_TCKS + 1;

  logic clk, rstN;
  logic cmdValid, cmdReady, rspValid, busy, tck, tdi, tdo, uir, cdr, sdr, udr, rti;
  logic [IR_W-1:0] cmdIr, irIn;
  logic [DR_W-1:0] cmdDr, rspDr;
  logic cmdValidF, cmdReadyF, rspValidF, busyF, tckF, tdiF, tdoF, uirF, cdrF, sdrF, udrF, rtiF;
  logic [IR_W-1:0] cmdIrF, irInF;
  logic [DR_W-1:0] cmdDrF, rspDrF;

  int vectors = 0;
  int failures = 0;
  int cyc = 0;

  nios2_jtag_debug_host #(.DR_W(DR_W), .IR_W(IR_W), .TCK_DIV(TCK_DIV), .RTI_CYCLES(RTI_CYCLES)) u_dut (
    .clk_i(clk), .rst_ni(rstN), .cmd_valid_i(cmdValid), .cmd_ready_o(cmdReady),
    .cmd_ir_i(cmdIr), .cmd_dr_i(cmdDr), .rsp_valid_o(rspValid), .rsp_dr_o(rspDr), .busy_o(busy),
    .vji_tck_o(tck), .vji_tdi_o(tdi), .vji_tdo_i(tdo), .vji_ir_in_o(irIn),
    .vji_uir_o(uir), .vji_cdr_o(cdr), .vji_sdr_o(sdr), .vji_udr_o(udr), .vji_rti_o(rti));

  nios2_jtag_debug_host #(.DR_W(DR_W), .IR_W(IR_W), .TCK_DIV(1), .RTI_CYCLES(RTI_CYCLES)) u_fast (
    .clk_i(clk), .rst_ni(rstN), .cmd_valid_i(cmdValidF), .cmd_ready_o(cmdReadyF),
    .cmd_ir_i(cmdIrF), .cmd_dr_i(cmdDrF), .rsp_valid_o(rspValidF), .rsp_dr_o(rspDrF), .busy_o(busyF),
    .vji_tck_o(tckF), .vji_tdi_o(tdiF), .vji_tdo_i(tdoF), .vji_ir_in_o(irInF),
    .vji_uir_o(uirF), .vji_cdr_o(cdrF), .vji_sdr_o(sdrF), .vji_udr_o(udrF), .vji_rti_o(rtiF));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Target model: capture on CDR, shift tdi in at the MSB on SDR, tdo = sr[0]
  logic [DR_W-1:0] tgtSr = '0;
  logic [DR_W-1:0] tgtCapVal = '0;
  logic [DR_W-1:0] tgtUdrSr = '0;
  int tckTotal = 0;
  logic [4:0] flagLog [0:4095];
  logic tdiLog [0:4095];
  assign tdo = tgtSr[0];

  always @(posedge tck) begin
    if (tckTotal < 4096) begin
      flagLog[tckTotal] <= {uir, cdr, sdr, udr, rti};
      tdiLog[tckTotal]  <= tdi;
    end
    tckTotal <= tckTotal + 1;
    if (cdr) tgtSr <= tgtCapVal;
    else if (sdr) tgtSr <= {tdi, tgtSr[DR_W-1:1]};
    if (udr) tgtUdrSr <= tgtSr;
  end

  logic [DR_W-1:0] srF = '0;
  logic [DR_W-1:0] capListF [0:7];
  logic [DR_W-1:0] udrLogF [0:7];
  int cdrIdxF = 0;
  int udrIdxF = 0;
  assign tdoF = srF[0];

  always @(posedge tckF) begin
    if (cdrF) begin
      srF     <= capListF[cdrIdxF % 8];
      cdrIdxF <= cdrIdxF + 1;
    end else if (sdrF) begin
      srF <= {tdiF, srF[DR_W-1:1]};
    end
    if (udrF) begin
      udrLogF[udrIdxF % 8] <= srF;
      udrIdxF <= udrIdxF + 1;
    end
  end

  logic lastTckF = 1'b0;
  int riseCountF = 0;
  int riseCycF [0:1023];
  always @(negedge clk) begin
    if (tckF && !lastTckF) begin
      riseCycF[riseCountF % 1024] <= cyc;
      riseCountF <= riseCountF + 1;
    end
    lastTckF <= tckF;
  end

  // The state flags may never have more than one bit set
  always @(negedge clk) begin
    if (rstN) begin
      vectors++;
      if ($countones({uir, cdr, sdr, udr, rti}) > 1 || $countones({uirF, cdrF, sdrF, udrF, rtiF}) > 1) begin
        failures++;
        $display("[TB] FAIL onehot: flags=%b fastFlags=%b required at most one set", {uir, cdr, sdr, udr, rti},
                 {uirF, cdrF, sdrF, udrF, rtiF});
      end
    end
  end

  task automatic test_reset();
    #12;
    vectors++;
    if ({cmdReady, busy, rspValid, tck, tdi, uir, cdr, sdr, udr, rti} !== 10'b10_0000_0001 || rspDr !== '0 || irIn !== '0) begin
      failures++;
      $display("[TB] FAIL reset_state: got %b rsp=%h ir=%b required 1000000001 rsp=0 ir=0",
               {cmdReady, busy, rspValid, tck, tdi, uir, cdr, sdr, udr, rti}, rspDr, irIn);
    end
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if ({cmdReady, busy, tck, rti} !== 4'b1001 || {cmdReadyF, busyF, tckF, rtiF} !== 4'b1001) begin
      failures++;
      $display("[TB] FAIL idle_after_reset: got %b/%b required 1001", {cmdReady, busy, tck, rti}, {cmdReadyF, busyF, tckF, rtiF});
    end
  endtask

  task automatic test_single_scan();
    logic [IR_W-1:0] ir;
    logic [DR_W-1:0] dr, capv;
    logic [4:0] expFlags;
    int base, accCyc, rspCyc;
    bit gotRsp;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) begin
        ir = 2'b01; dr = 38'h2A_AAAA_AAAA; capv = 38'h15_5555_5555;
      end else begin
        ir = IR_W'($urandom); dr = DR_W'({$urandom, $urandom}); capv = DR_W'({$urandom, $urandom});
      end
      tgtCapVal = capv;
      @(negedge clk);
      vectors++;
      if (cmdReady !== 1'b1) begin
        failures++;
        $display("[TB] FAIL scan_ready: got %b required 1", cmdReady);
      end
      base = tckTotal;
      cmdValid = 1'b1; cmdIr = ir; cmdDr = dr;
      @(posedge clk);
      #1;
      accCyc = cyc;
      cmdValid = 1'b0; cmdIr = ~ir; cmdDr = ~dr;
      vectors++;
      if ({cmdReady, busy, irIn} !== {1'b0, 1'b1, ir}) begin
        failures++;
        $display("[TB] FAIL scan_accept: ready/busy/ir=%b required %b", {cmdReady, busy, irIn}, {1'b0, 1'b1, ir});
      end
      gotRsp = 1'b0;
      for (int n = 0; n < LAT + 50 && !gotRsp; n++) begin
        @(posedge clk);
        #1;
        if (rspValid) gotRsp = 1'b1;
      end
      rspCyc = cyc;
      vectors++;
      if (!gotRsp || rspCyc - accCyc !== LAT) begin
        failures++;
        $display("[TB] FAIL scan_latency: seen=%0d after %0d clk required %0d", gotRsp, rspCyc - accCyc, LAT);
      end
      vectors++;
      if (rspDr !== capv || cmdReady !== 1'b1) begin
        failures++;
        $display("[TB] FAIL scan_rsp: rsp=%h ready=%b required %h ready=1", rspDr, cmdReady, capv);
      end
      vectors++;
      if (tckTotal - base !== SCAN_TCKS || tgtUdrSr !== dr) begin
        failures++;
        $display("[TB] FAIL scan_tck_data: tcks=%0d target=%h required %0d %h", tckTotal - base, tgtUdrSr, SCAN_TCKS, dr);
      end
      for (int k = 0; k < SCAN_TCKS; k++) begin
        if (k == 0) expFlags = 5'b10000;
        else if (k == 1) expFlags = 5'b01000;
        else if (k < DR_W + 2) expFlags = 5'b00100;
        else if (k == DR_W + 2) expFlags = 5'b00010;
        else expFlags = 5'b00001;
        vectors++;
        if (flagLog[base + k] !== expFlags || (k >= 2 && k < DR_W + 2 && tdiLog[base + k] !== dr[k - 2])) begin
          failures++;
          $display("[TB] FAIL scan_sequence tck %0d: flags=%b tdi=%b required flags=%b", k, flagLog[base + k],
                   tdiLog[base + k], expFlags);
        end
      end
      @(posedge clk);
      #1;
      vectors++;
      if (rspValid !== 1'b0 || rspDr !== capv) begin
        failures++;
        $display("[TB] FAIL rsp_pulse: valid=%b rsp=%h required 0 %h", rspValid, rspDr, capv);
      end
    end
  endtask

  task automatic test_busy();
    logic [IR_W-1:0] ir;
    logic [DR_W-1:0] dr, capv;
    int base, accCyc;
    bit gotRsp;
    ir = 2'b10; dr = DR_W'({$urandom, $urandom}); capv = DR_W'({$urandom, $urandom});
    tgtCapVal = capv;
    @(negedge clk);
    base = tckTotal;
    cmdValid = 1'b1; cmdIr = ir; cmdDr = dr;
    @(posedge clk);
    #1;
    accCyc = cyc;
    cmdValid = 1'b0;
    for (int n = 0; n < 400 && tckTotal - base < 12; n++) @(negedge clk);
    cmdValid = 1'b1; cmdIr = ~ir; cmdDr = ~dr;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      vectors++;
      if (cmdReady !== 1'b0 || busy !== 1'b1 || sdr !== 1'b1) begin
        failures++;
        $display("[TB] FAIL busy_ready: ready=%b busy=%b sdr=%b required 0 1 1", cmdReady, busy, sdr);
      end
    end
    cmdValid = 1'b0;
    gotRsp = 1'b0;
    for (int n = 0; n < LAT + 50 && !gotRsp; n++) begin
      @(posedge clk);
      #1;
      if (rspValid) gotRsp = 1'b1;
    end
    vectors++;
    if (!gotRsp || cyc - accCyc !== LAT) begin
      failures++;
      $display("[TB] FAIL busy_latency: seen=%0d after %0d clk required %0d", gotRsp, cyc - accCyc, LAT);
    end
    vectors++;
    if (rspDr !== capv || tgtUdrSr !== dr || irIn !== ir) begin
      failures++;
      $display("[TB] FAIL busy_ignored: rsp=%h target=%h ir=%b required %h %h %b", rspDr, tgtUdrSr, irIn, capv, dr, ir);
    end
  endtask

  task automatic test_reset_mid_sdr();
    logic [IR_W-1:0] ir;
    logic [DR_W-1:0] dr, capv;
    int base, accCyc;
    bit gotRsp, sawRsp;
    ir = IR_W'($urandom); dr = DR_W'({$urandom, $urandom}); capv = DR_W'({$urandom, $urandom});
    tgtCapVal = capv;
    @(negedge clk);
    base = tckTotal;
    cmdValid = 1'b1; cmdIr = ir; cmdDr = dr;
    @(posedge clk);
    #1;
    cmdValid = 1'b0;
    for (int n = 0; n < 400 && tckTotal - base < 23; n++) @(negedge clk);
    vectors++;
    if (sdr !== 1'b1 || tckTotal - base !== 23) begin
      failures++;
      $display("[TB] FAIL abort_reach: sdr=%b tcks=%0d required 1 23", sdr, tckTotal - base);
    end
    #2;
    rstN = 1'b0;
    #1;
    vectors++;
    if ({cmdReady, busy, rspValid, tck, tdi, uir, cdr, sdr, udr, rti} !== 10'b10_0000_0001 || rspDr !== '0 || irIn !== '0) begin
      failures++;
      $display("[TB] FAIL abort_async: got %b rsp=%h ir=%b required 1000000001 0 0",
               {cmdReady, busy, rspValid, tck, tdi, uir, cdr, sdr, udr, rti}, rspDr, irIn);
    end
    @(posedge clk);
    #1;
    vectors++;
    if ({cmdReady, busy, rspValid, tck, tdi, uir, cdr, sdr, udr, rti} !== 10'b10_0000_0001) begin
      failures++;
      $display("[TB] FAIL abort_next_clk: got %b required 1000000001", {cmdReady, busy, rspValid, tck, tdi, uir, cdr, sdr, udr, rti});
    end
    @(negedge clk);
    rstN = 1'b1;
    sawRsp = 1'b0;
    for (int n = 0; n < LAT + 20; n++) begin
      @(posedge clk);
      #1;
      if (rspValid) sawRsp = 1'b1;
    end
    vectors++;
    if (sawRsp !== 1'b0) begin
      failures++;
      $display("[TB] FAIL abort_no_rsp: rsp_valid seen=%b required 0", sawRsp);
    end
    ir = IR_W'($urandom); dr = DR_W'({$urandom, $urandom}); capv = DR_W'({$urandom, $urandom});
    tgtCapVal = capv;
    @(negedge clk);
    cmdValid = 1'b1; cmdIr = ir; cmdDr = dr;
    @(posedge clk);
    #1;
    accCyc = cyc;
    cmdValid = 1'b0;
    gotRsp = 1'b0;
    for (int n = 0; n < LAT + 50 && !gotRsp; n++) begin
      @(posedge clk);
      #1;
      if (rspValid) gotRsp = 1'b1;
    end
    vectors++;
    if (!gotRsp || cyc - accCyc !== LAT || rspDr !== capv || tgtUdrSr !== dr || irIn !== ir) begin
      failures++;
      $display("[TB] FAIL fresh_scan: seen=%0d lat=%0d rsp=%h target=%h required lat %0d rsp %h target %h",
               gotRsp, cyc - accCyc, rspDr, tgtUdrSr, LAT, capv, dr);
    end
  endtask

  task automatic test_back_to_back();
    logic [IR_W-1:0] ir1, ir2, irAtAcc2;
    logic [DR_W-1:0] dr1, dr2, cap1, cap2, rsp1Dr, rsp2Dr;
    int acc1, acc2, rsp1, rsp2, uBase, rBase, badPeriods;
    bit got1, got2;
    ir1 = 2'b01; ir2 = 2'b10;
    dr1 = DR_W'({$urandom, $urandom}); dr2 = DR_W'({$urandom, $urandom});
    cap1 = DR_W'({$urandom, $urandom}); cap2 = DR_W'({$urandom, $urandom});
    capListF[cdrIdxF % 8] = cap1;
    capListF[(cdrIdxF + 1) % 8] = cap2;
    uBase = udrIdxF; rBase = riseCountF;
    @(negedge clk);
    cmdValidF = 1'b1; cmdIrF = ir1; cmdDrF = dr1;
    @(posedge clk);
    #1;
    acc1 = cyc;
    vectors++;
    if (irInF !== ir1) begin
      failures++;
      $display("[TB] FAIL b2b_first_ir: got %b required %b", irInF, ir1);
    end
    cmdIrF = ir2; cmdDrF = dr2;
    got1 = 1'b0; got2 = 1'b0; acc2 = -1; rsp1 = 0; rsp2 = 0;
    irAtAcc2 = '0; rsp1Dr = '0; rsp2Dr = '0;
    for (int n = 0; n < 3 * LAT_F && !got2; n++) begin
      @(posedge clk);
      #1;
      if (acc2 < 0 && irInF !== ir1) begin
        acc2 = cyc; irAtAcc2 = irInF; cmdValidF = 1'b0;
      end
      if (rspValidF) begin
        if (!got1) begin got1 = 1'b1; rsp1 = cyc; rsp1Dr = rspDrF; end
        else begin got2 = 1'b1; rsp2 = cyc; rsp2Dr = rspDrF; end
      end
    end
    cmdValidF = 1'b0;
    vectors++;
    if (!got1 || rsp1 - acc1 !== LAT_F || rsp1Dr !== cap1) begin
      failures++;
      $display("[TB] FAIL b2b_first_rsp: seen=%0d lat=%0d rsp=%h required lat %0d rsp %h", got1, rsp1 - acc1, rsp1Dr, LAT_F, cap1);
    end
    vectors++;
    if (acc2 - rsp1 !== 1 || irAtAcc2 !== ir2) begin
      failures++;
      $display("[TB] FAIL b2b_second_accept: %0d clk after rsp ir=%b required 1 clk ir=%b", acc2 - rsp1, irAtAcc2, ir2);
    end
    vectors++;
    if (!got2 || rsp2 - acc2 !== LAT_F || rsp2Dr !== cap2) begin
      failures++;
      $display("[TB] FAIL b2b_second_rsp: seen=%0d lat=%0d rsp=%h required lat %0d rsp %h", got2, rsp2 - acc2, rsp2Dr, LAT_F, cap2);
    end
    vectors++;
    if (udrLogF[uBase % 8] !== dr1 || udrLogF[(uBase + 1) % 8] !== dr2) begin
      failures++;
      $display("[TB] FAIL b2b_shifted: got %h %h required %h %h", udrLogF[uBase % 8], udrLogF[(uBase + 1) % 8], dr1, dr2);
    end
    badPeriods = 0;
    for (int j = 1; j < SCAN_TCKS; j++)
      if (riseCycF[(rBase + j) % 1024] - riseCycF[(rBase + j - 1) % 1024] != 2) badPeriods++;
    vectors++;
    if (badPeriods !== 0 || riseCountF - rBase !== 2 * SCAN_TCKS || riseCycF[rBase % 1024] - acc1 !== 1) begin
      failures++;
      $display("[TB] FAIL b2b_tck_period: bad periods=%0d rises=%0d first rise +%0d required 0 %0d +1",
               badPeriods, riseCountF - rBase, riseCycF[rBase % 1024] - acc1, 2 * SCAN_TCKS);
    end
    vectors++;
    if (riseCycF[(rBase + SCAN_TCKS) % 1024] - riseCycF[(rBase + SCAN_TCKS - 1) % 1024] !== 4) begin
      failures++;
      $display("[TB] FAIL b2b_gap: rise gap %0d clk required 4",
               riseCycF[(rBase + SCAN_TCKS) % 1024] - riseCycF[(rBase + SCAN_TCKS - 1) % 1024]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rstN = 1'b0;
    cmdValid = 1'b0; cmdIr = '0; cmdDr = '0;
    cmdValidF = 1'b0; cmdIrF = '0; cmdDrF = '0;
    test_reset();
    test_single_scan();
    test_busy();
    test_reset_mid_sdr();
    test_back_to_back();
    repeat (4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, failures);
    $finish;
  end

endmodule
